rob_commit_unit: RTL
====================

# rob_commit_unit

In-order reorder buffer that closes the rename loop. It takes a slot for every renamed instruction at dispatch and records completion from writeback. It retires entries strictly in program order, one per cycle. The retire side drives the commit interface of the rename/arch-register-file block (`commit_valid`, `commit_with_write`, `commited_wr_register`), which frees the previous physical mapping of the committed destination.

## Interface
- `ROB_ADDR_WIDTH`, default 4: log2 of entry count (16 entries).
- `PHYSICAL_REG_NUM_WIDTH`, default `` `PHYSICAL_REG_NUM_WIDTH ``: physical register id width.
- `ARCH_REG_NUM_WIDTH`, default `` `ARCH_REG_NUM_WIDTH ``: architectural register id width.

Ports (reset `reset`, asynchronous, active-high; clock `clk`):
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous active-high reset.
- `alloc_valid`  in  1  dispatch requests an entry.
- `alloc_with_write`  in  1  instruction writes a destination register.
- `alloc_phy_wr_reg`  in  PHYSICAL_REG_NUM_WIDTH  newly allocated physical destination (rename output `phy_write_reg_num`).
- `alloc_arch_wr_reg`  in  ARCH_REG_NUM_WIDTH  architectural destination.
- `alloc_ready`  out  1  entry available (not full).
- `alloc_rob_id`  out  ROB_ADDR_WIDTH  tag assigned to the instruction accepted this cycle.
- `wb_valid`  in  1  execution completion strobe.
- `wb_rob_id`  in  ROB_ADDR_WIDTH  tag of the completing instruction.
- `commit_valid`  out  1  head entry retires this cycle.
- `commit_with_write`  out  1  retiring entry has a destination.
- `commited_wr_register`  out  PHYSICAL_REG_NUM_WIDTH  physical destination of the retiring entry.
- `commit_arch_wr_reg`  out  ARCH_REG_NUM_WIDTH  architectural destination of the retiring entry.
- `commit_rob_id`  out  ROB_ADDR_WIDTH  tag of the retiring entry.
- `rob_empty`  out  1  no valid entries.
- `rob_full`  out  1  all entries valid.
- `commit_count`  out  32  retired-instruction counter (only with `ROB_PERF_CNT_EN`).

## Operation

**Storage**
- Circular buffer of 2^ROB_ADDR_WIDTH entries.
- Each entry holds {valid, done, with_write, phy, arch}.
- `head` and `tail` are ROB_ADDR_WIDTH+1 bits; the MSB is the wrap bit.
- Empty when head==tail. Full when the index bits are equal and the wrap bits differ.

**Allocate**
- `alloc_ready = ~rob_full`, from registered state only. There is no same-cycle commit bypass, so when full, allocation is refused even if commit_valid=1.
- On `alloc_valid & alloc_ready`: write the entry at tail[ROB_ADDR_WIDTH-1:0] with valid=1, done=0 and the captured fields; tail increments.
- `alloc_rob_id = tail[ROB_ADDR_WIDTH-1:0]`, combinational.
- `alloc_valid` while not ready is dropped; dispatch must hold the request.

**Writeback**
- On `wb_valid`: set done=1 in entry `wb_rob_id` only if that entry is valid. Writeback to an invalid entry is ignored.
- A repeated writeback to a done entry has no effect.

**Commit**
- `commit_valid = entry[head].valid & entry[head].done`, combinational from registered state.
- When commit_valid=1: commit fields come from the head entry. At the next edge, entry[head].valid is cleared and head increments.
- When commit_valid=0: `commit_with_write`, `commited_wr_register`, `commit_arch_wr_reg` and `commit_rob_id` are driven 0.
- `commited_wr_register` is the physical register allocated by the retiring instruction. The rename block uses it to free the old mapping.
- At most one commit per cycle. Entries behind an incomplete head wait even if they are done.

**Simultaneous events**
- Alloc and commit in the same cycle: both happen; occupancy is unchanged.
- Writeback to the head entry in cycle N: commit_valid rises in cycle N+1.
- Wrap-around: index bits roll over from 2^ROB_ADDR_WIDTH-1 to 0 and the wrap bit toggles.

## Timing
- Reset (async, any time including mid-operation): head=tail=0, all valid/done=0, in-flight entries discarded.
- Output values in reset: alloc_ready=1, alloc_rob_id=0, commit_valid=0, all commit fields=0, rob_empty=1, rob_full=0, commit_count=0.
- Minimum latency: alloc accepted at edge N → writeback in cycle N (after the edge) → commit_valid in cycle N+1 → head advances at edge N+2.
- `rob_empty`, `rob_full` and `alloc_ready` are registered-state decodes. They have no combinational path from `alloc_valid` or `wb_valid`.
- Sustained throughput is one alloc and one commit per cycle.

## Configuration
- `ROB_PERF_CNT_EN` defined:
  - `commit_count` port exists.
  - 32-bit counter increments on every edge where commit_valid=1.
  - Wraps modulo 2^32; reset to 0.
- Not defined: `commit_count` port and counter are absent. All other behaviour is identical.

## Test plan
- Reset, then 3 allocs (phy 32,33,34; arch 1,2,3; with_write=1), wb in order 0,1,2 → commits of phy 32,33,34 on three consecutive cycles; rob_empty=1 afterwards.
- Allocs to tags 0,1,2; wb order 2,1,0 → no commit until tag 0 done; then tags 0,1,2 retire on three consecutive cycles in order.
- Fill 16 entries → rob_full=1, alloc_ready=0. A 17th alloc_valid is dropped. wb tag 0 → commit; alloc_ready=1 the cycle after head advances; the next tag is 0 with the wrap bit set.
- Alloc with alloc_with_write=0 and wb → commit_valid=1, commit_with_write=0, commited_wr_register=0. Also check wb_valid to an unallocated tag 7 → no state change.
- Assert reset mid-stream with 5 valid entries → all outputs return to reset values immediately. With `ROB_PERF_CNT_EN`, commit_count equals the commits before reset and is 0 after.

Source files
------------

// File: rtl/rob_commit_unit.sv
// rob_commit_unit: in-order reorder buffer, one alloc and one commit per cycle.
// Optional ROB_PERF_CNT_EN adds the 32-bit commit_count retired-instruction counter.
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef ARCH_REG_NUM_WIDTH
`define ARCH_REG_NUM_WIDTH 5
`endif
module rob_commit_unit #(
   parameter int ROB_ADDR_WIDTH         = 4,
   parameter int PHYSICAL_REG_NUM_WIDTH = `PHYSICAL_REG_NUM_WIDTH,
   parameter int ARCH_REG_NUM_WIDTH     = `ARCH_REG_NUM_WIDTH
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              alloc_valid,
   input  logic                              alloc_with_write,
   input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] alloc_phy_wr_reg,
   input  logic [ARCH_REG_NUM_WIDTH-1:0]     alloc_arch_wr_reg,
   output logic                              alloc_ready,
   output logic [ROB_ADDR_WIDTH-1:0]         alloc_rob_id,
   input  logic                              wb_valid,
   input  logic [ROB_ADDR_WIDTH-1:0]         wb_rob_id,
   output logic                              commit_valid,
   output logic                              commit_with_write,
   output logic [PHYSICAL_REG_NUM_WIDTH-1:0] commited_wr_register,
   output logic [ARCH_REG_NUM_WIDTH-1:0]     commit_arch_wr_reg,
   output logic [ROB_ADDR_WIDTH-1:0]         commit_rob_id,
   output logic                              rob_empty,
   output logic                              rob_full
`ifdef ROB_PERF_CNT_EN
   ,
   output logic [31:0]                       commit_count
`endif
);
   localparam int DEPTH = 1 << ROB_ADDR_WIDTH;
   localparam logic [ROB_ADDR_WIDTH:0] PTR_ONE = 1;
   logic [DEPTH-1:0] valid, done, with_write;
   logic [PHYSICAL_REG_NUM_WIDTH-1:0] phy [DEPTH];
   logic [ARCH_REG_NUM_WIDTH-1:0] arch [DEPTH];
   logic [ROB_ADDR_WIDTH:0] head, tail;
   logic [ROB_ADDR_WIDTH-1:0] hi, ti;
   logic alloc_fire;
   // Pointer decodes and head-entry view; everything here depends on registered state only.
   always_comb begin
      hi = head[ROB_ADDR_WIDTH-1:0];
      ti = tail[ROB_ADDR_WIDTH-1:0];
      rob_empty = head == tail;
      rob_full = (hi == ti) && (head[ROB_ADDR_WIDTH] != tail[ROB_ADDR_WIDTH]);
      alloc_ready = ~rob_full;
      alloc_rob_id = ti;
      alloc_fire = alloc_valid & alloc_ready;
      commit_valid = valid[hi] & done[hi];
      commit_with_write = commit_valid ? with_write[hi] : 1'b0;
      commited_wr_register = commit_valid ? phy[hi] : '0;
      commit_arch_wr_reg = commit_valid ? arch[hi] : '0;
      commit_rob_id = commit_valid ? hi : '0;
   end
   // Control state: pointers plus per-entry valid/done. Alloc and commit never hit the same
   // index in one cycle (that would need full and empty at once), so the updates are disjoint.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head <= '0;
         tail <= '0;
         valid <= '0;
         done <= '0;
      end else begin
         if (alloc_fire) begin
            valid[ti] <= 1'b1;
            done[ti] <= 1'b0;
            tail <= tail + PTR_ONE;
         end
         if (wb_valid && valid[wb_rob_id]) done[wb_rob_id] <= 1'b1;
         if (commit_valid) begin
            valid[hi] <= 1'b0;
            head <= head + PTR_ONE;
         end
      end
   end
   // Entry payload; needs no reset because commit outputs are gated by commit_valid.
   always_ff @(posedge clk) begin
      if (alloc_fire) begin
         with_write[ti] <= alloc_with_write;
         phy[ti] <= alloc_phy_wr_reg;
         arch[ti] <= alloc_arch_wr_reg;
      end
   end
`ifdef ROB_PERF_CNT_EN
   // Retired-instruction counter, wraps modulo 2^32.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) commit_count <= '0;
      else if (commit_valid) commit_count <= commit_count + 32'd1;
   end
`endif
endmodule
